// File: rtl/cache_pkg.sv
// cache_pkg: shared state type, default geometry and byte-merge helper for the cache
package cache_pkg;
   typedef enum logic [1:0] {IDLE, FILL, WRITE} cache_state_t;
   localparam int DEF_OFFSET_BITS = 4;
   localparam int DEF_SET_BITS = 5;
   localparam int DEF_WAYS = 2;
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word, input logic [31:0] new_word, input logic [3:0] mask);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = mask[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/cache_way_array.sv
// cache_way_array: one way's tag, valid and data storage with tag compare
module cache_way_array #(
   parameter int TAG_BITS = 23,
   parameter int SET_BITS = 5,
   parameter int WORD_BITS = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_inval,
   input  logic [SET_BITS-1:0]  i_rd_idx,
   input  logic [TAG_BITS-1:0]  i_rd_tag,
   input  logic [WORD_BITS-1:0] i_rd_word,
   output logic                 o_valid,
   output logic                 o_hit,
   output logic [31:0]          o_rdata,
   input  logic                 i_wr_en,
   input  logic [SET_BITS-1:0]  i_wr_idx,
   input  logic [WORD_BITS-1:0] i_wr_word,
   input  logic [31:0]          i_wr_data,
   input  logic                 i_tag_en,
   input  logic [TAG_BITS-1:0]  i_tag
);
   localparam int SETS = 1 << SET_BITS;
   logic [SETS-1:0] valid;
   logic [TAG_BITS-1:0] tags [SETS];
   logic [31:0] data [SETS << WORD_BITS];
   assign o_valid = valid[i_rd_idx];
   assign o_hit = o_valid && tags[i_rd_idx] == i_rd_tag;
   assign o_rdata = o_hit ? data[{i_rd_idx, i_rd_word}] : '0;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) valid <= '0;
      else if (i_inval) valid <= '0;
      else if (i_tag_en) valid[i_wr_idx] <= 1'b1;
   always_ff @(posedge i_clk) begin
      if (i_tag_en) tags[i_wr_idx] <= i_tag;
      if (i_wr_en) data[{i_wr_idx, i_wr_word}] <= i_wr_data;
   end
endmodule

// File: rtl/wt_cache_param.sv
// wt_cache_param: write-through, write-allocate, N-way set-associative cache
// with NMRU replacement and a pipelined multi-word line fill.
module wt_cache_param
   import cache_pkg::*;
#(
   parameter int OFFSET_BITS = DEF_OFFSET_BITS,
   parameter int SET_BITS = DEF_SET_BITS,
   parameter int WAYS = DEF_WAYS
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_mem_ready,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_ren,
   output logic        o_mem_wen,
   output logic [31:0] o_mem_wdata,
   input  logic [31:0] i_mem_rdata,
   input  logic        i_mem_valid,
   output logic        o_busy,
   input  logic [31:0] i_req_addr,
   input  logic        i_req_ren,
   input  logic        i_req_wen,
   input  logic [3:0]  i_req_mask,
   input  logic [31:0] i_req_wdata,
   output logic [31:0] o_res_rdata,
   input  logic        i_inval
);
   localparam int WB = OFFSET_BITS - 2;
   localparam int WORDS = 1 << WB;
   localparam int TAG_BITS = 32 - OFFSET_BITS - SET_BITS;
   localparam int SETS = 1 << SET_BITS;
   localparam int WAY_BITS = WAYS > 1 ? $clog2(WAYS) : 1;
   cache_state_t state;
   logic [TAG_BITS-1:0] l_tag, req_tag;
   logic [SET_BITS-1:0] l_idx, req_idx;
   logic [WB-1:0] req_word, recv_cnt;
   logic [WB:0] issue_cnt;
   logic l_write, wr_done;
   logic [WAY_BITS-1:0] l_vic, vic, hit_way;
   logic [WAY_BITS-1:0] mru [SETS];
   logic [WAYS-1:0] hit_v, vld_v, we_v;
   logic [31:0] way_rdata [WAYS];
   logic [31:0] hit_rdata, merged;
   logic idle, hit, miss, wr_hit, wr_commit, fill_ret, last_ret;
   assign req_tag = i_req_addr[31 -: TAG_BITS];
   assign req_idx = i_req_addr[OFFSET_BITS +: SET_BITS];
   assign req_word = i_req_addr[2 +: WB];
   for (genvar w = 0; w < WAYS; w++) begin : g_way
      assign we_v[w] = (fill_ret && l_vic == WAY_BITS'(w)) || (wr_commit && hit_v[w]);
      cache_way_array #(.TAG_BITS(TAG_BITS), .SET_BITS(SET_BITS), .WORD_BITS(WB)) u_way (
         .i_clk(i_clk), .i_rst(i_rst), .i_inval(i_inval),
         .i_rd_idx(req_idx), .i_rd_tag(req_tag), .i_rd_word(req_word),
         .o_valid(vld_v[w]), .o_hit(hit_v[w]), .o_rdata(way_rdata[w]),
         .i_wr_en(we_v[w]), .i_wr_idx(fill_ret ? l_idx : req_idx), .i_wr_word(fill_ret ? recv_cnt : req_word),
         .i_wr_data(fill_ret ? i_mem_rdata : merged),
         .i_tag_en(last_ret && l_vic == WAY_BITS'(w)), .i_tag(l_tag));
   end
   always_comb begin
      hit_rdata = '0;
      hit_way = '0;
      vic = WAYS == 1 ? '0 : WAY_BITS'(mru[req_idx] + 1'b1);
      for (int i = WAYS - 1; i >= 0; i--) begin
         hit_rdata |= way_rdata[i];
         if (hit_v[i]) hit_way = WAY_BITS'(i);
         if (!vld_v[i]) vic = WAY_BITS'(i);
      end
   end
   assign idle = state == IDLE;
   assign hit = |hit_v;
   assign merged = merge_bytes(hit_rdata, i_req_wdata, i_req_mask);
   assign miss = idle && (i_req_ren || i_req_wen) && !hit;
   // The held request is still presented in the cycle busy drops after WRITE; it is already written.
   assign wr_hit = idle && i_req_wen && hit && !wr_done;
   assign wr_commit = i_mem_ready && (wr_hit || state == WRITE);
   assign fill_ret = state == FILL && i_mem_valid;
   assign last_ret = fill_ret && recv_cnt == WB'(WORDS - 1);
   assign o_mem_ren = state == FILL && issue_cnt < (WB+1)'(WORDS);
   assign o_mem_wen = (wr_hit && i_mem_ready) || state == WRITE;
   assign o_mem_addr = state == FILL ? {l_tag, l_idx, issue_cnt[WB-1:0], 2'b00} : o_mem_wen ? i_req_addr & ~32'h3 : '0;
   assign o_mem_wdata = o_mem_wen ? merged : '0;
   assign o_busy = !idle || miss || (wr_hit && !i_mem_ready);
   assign o_res_rdata = hit_rdata;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
         state <= IDLE;
         l_tag <= '0;
         l_idx <= '0;
         l_write <= 1'b0;
         l_vic <= '0;
         issue_cnt <= '0;
         recv_cnt <= '0;
         wr_done <= 1'b0;
         for (int i = 0; i < SETS; i++) mru[i] <= '0;
      end else begin
         wr_done <= state == WRITE && i_mem_ready;
         if (o_mem_ren && i_mem_ready) issue_cnt <= issue_cnt + 1'b1;
         if (fill_ret) recv_cnt <= recv_cnt + 1'b1;
         if (miss) begin
            state <= FILL;
            l_tag <= req_tag;
            l_idx <= req_idx;
            l_write <= i_req_wen;
            l_vic <= vic;
            issue_cnt <= '0;
            recv_cnt <= '0;
         end
         if (last_ret) begin
            mru[l_idx] <= l_vic;
            state <= l_write ? WRITE : IDLE;
         end
         if (idle && hit && (i_req_ren || (wr_hit && i_mem_ready))) mru[req_idx] <= hit_way;
         if (wr_hit && !i_mem_ready) state <= WRITE;
         if (state == WRITE && i_mem_ready) begin
            mru[req_idx] <= hit_way;
            state <= IDLE;
         end
      end
endmodule

// File: tb/tb_wt_cache_param.sv
// tb_wt_cache_param: directed bench for wt_cache_param with a 1-cycle-latency memory model;
// u0 uses the default geometry, u1 is 4-way with 8-word lines.
module tb_wt_cache_param;
   logic i_clk = 0, i_rst = 1;
   logic i_mem_ready, i_mem_valid;
   logic [31:0] i_mem_rdata;
   logic [31:0] req_addr = 0, req_wdata = 0;
   logic [3:0] req_mask = 0;
   logic req_ren = 0, req_wen = 0, inval = 0, sel = 0, inj = 0, mvalid = 0, cr = 0;
   logic [31:0] mrdata = 0, ca = 0;
   logic [31:0] addr0, addr1, wd0, wd1, rd0, rd1;
   logic ren0, ren1, wen0, wen1, busy0, busy1;
   logic [31:0] m_addr, m_wdata, rdata;
   logic m_ren, m_wen, busy;
   logic [31:0] mem [logic [31:0]];
   logic [31:0] first_rd, last_rd, last_wa, last_wd;
   int hold = 0, n_chk = 0, n_bad = 0, n_rd = 0, n_wr = 0;
   always #5 i_clk = ~i_clk;
   assign i_mem_ready = hold == 0;
   assign i_mem_valid = mvalid | inj;
   assign i_mem_rdata = inj ? 32'hDEADBEEF : mrdata;
   assign m_ren = sel ? ren1 : ren0;
   assign m_wen = sel ? wen1 : wen0;
   assign m_addr = sel ? addr1 : addr0;
   assign m_wdata = sel ? wd1 : wd0;
   assign busy = sel ? busy1 : busy0;
   assign rdata = sel ? rd1 : rd0;
   wt_cache_param u0 (
      .i_clk(i_clk), .i_rst(i_rst), .i_mem_ready(i_mem_ready), .o_mem_addr(addr0), .o_mem_ren(ren0),
      .o_mem_wen(wen0), .o_mem_wdata(wd0), .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid),
      .o_busy(busy0), .i_req_addr(req_addr), .i_req_ren(req_ren & ~sel), .i_req_wen(req_wen & ~sel),
      .i_req_mask(req_mask), .i_req_wdata(req_wdata), .o_res_rdata(rd0), .i_inval(inval));
   wt_cache_param #(.OFFSET_BITS(5), .SET_BITS(5), .WAYS(4)) u1 (
      .i_clk(i_clk), .i_rst(i_rst), .i_mem_ready(i_mem_ready), .o_mem_addr(addr1), .o_mem_ren(ren1),
      .o_mem_wen(wen1), .o_mem_wdata(wd1), .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid),
      .o_busy(busy1), .i_req_addr(req_addr), .i_req_ren(req_ren & sel), .i_req_wen(req_wen & sel),
      .i_req_mask(req_mask), .i_req_wdata(req_wdata), .o_res_rdata(rd1), .i_inval(inval));
   function automatic logic [31:0] pat(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction
   function automatic logic [31:0] memrd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : pat(a);
   endfunction
   always @(posedge i_clk) begin
      cr = m_ren & i_mem_ready;
      ca = m_addr;
      if (m_wen && i_mem_ready) begin
         mem[m_addr] = m_wdata;
         n_wr++;
         last_wa = m_addr;
         last_wd = m_wdata;
      end
      if (cr) begin
         if (n_rd == 0) first_rd = ca;
         last_rd = ca;
         n_rd++;
      end
      #1;
      if (hold > 0) hold--;
      mvalid = cr;
      mrdata = memrd(ca);
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask
   task automatic access(input logic [31:0] a, input logic w, input logic [3:0] m, input logic [31:0] d, output int cyc);
      req_addr = a;
      req_ren = !w;
      req_wen = w;
      req_mask = m;
      req_wdata = d;
      cyc = 0;
      #1;
      while (busy && cyc < 100) begin
         tick();
         cyc++;
      end
      if (cyc >= 100) check("busy timeout", busy, 0);
   endtask
   task automatic done_req();
      tick();
      req_ren = 0;
      req_wen = 0;
   endtask
   logic [31:0] t3a [6] = '{32'h1000, 32'h1400, 32'h1000, 32'h1800, 32'h1000, 32'h1400};
   int t3c [6] = '{6, 6, 0, 6, 0, 6};
   logic [31:0] t6a [4] = '{32'h300, 32'h100, 32'h1000, 32'h2040};
   initial begin
      int c, w0;
      mem[32'h200] = 32'h11223344;
      #2;
      check("rst busy", busy0, 0);
      check("rst ren", ren0, 0);
      check("rst wen", wen0, 0);
      check("rst addr", addr0, 0);
      check("rst wdata", wd0, 0);
      check("rst rdata", rd0, 0);
      @(posedge i_clk);
      #2 i_rst = 0;
      n_rd = 0;
      access(32'h100, 0, 0, 0, c);
      check("t1 miss cycles", c, 6);
      check("t1 reads", n_rd, 4);
      check("t1 first addr", first_rd, 32'h100);
      check("t1 last addr", last_rd, 32'h10C);
      check("t1 data", rdata, pat(32'h100));
      done_req();
      access(32'h104, 0, 0, 0, c);
      check("t1 hit cycles", c, 0);
      check("t1 hit data", rdata, pat(32'h104));
      done_req();
      w0 = n_wr;
      access(32'h200, 1, 4'b0010, 32'h0000AB00, c);
      check("t2 wmiss cycles", c, 7);
      check("t2 writes", n_wr - w0, 1);
      check("t2 waddr", last_wa, 32'h200);
      check("t2 wdata", last_wd, 32'h1122AB44);
      done_req();
      check("t2 writes after", n_wr - w0, 1);
      access(32'h200, 0, 0, 0, c);
      check("t2 read cycles", c, 0);
      check("t2 read data", rdata, 32'h1122AB44);
      done_req();
      for (int i = 0; i < 6; i++) begin
         access(t3a[i], 0, 0, 0, c);
         check($sformatf("t3 cycles %0d", i), c, t3c[i]);
         check($sformatf("t3 data %0d", i), rdata, pat(t3a[i]));
         done_req();
      end
      hold = 3;
      w0 = n_wr;
      access(32'h104, 1, 4'hF, 32'hCAFEF00D, c);
      check("t4 busy cycles", c, 4);
      check("t4 writes", n_wr - w0, 1);
      check("t4 wdata", last_wd, 32'hCAFEF00D);
      done_req();
      check("t4 writes after", n_wr - w0, 1);
      access(32'h104, 0, 0, 0, c);
      check("t4 read cycles", c, 0);
      check("t4 read data", rdata, 32'hCAFEF00D);
      done_req();
      req_addr = 32'h300;
      req_ren = 1;
      repeat (4) tick();
      check("t5 ren mid fill", ren0, 1);
      i_rst = 1;
      req_ren = 0;
      #1;
      check("t5 ren in rst", ren0, 0);
      check("t5 busy in rst", busy0, 0);
      check("t5 addr in rst", addr0, 0);
      tick();
      i_rst = 0;
      inj = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("t5 busy late valid", busy0, 0);
         check("t5 ren late valid", ren0, 0);
      end
      inj = 0;
      for (int i = 0; i < 4; i++) begin
         access(t6a[i], 0, 0, 0, c);
         check($sformatf("t6 fill %0d", i), c, 6);
         check($sformatf("t6 fill data %0d", i), rdata, pat(t6a[i]));
         done_req();
      end
      inval = 1;
      tick();
      inval = 0;
      for (int i = 0; i < 4; i++) begin
         access(t6a[i], 0, 0, 0, c);
         check($sformatf("t6 inval miss %0d", i), c, 6);
         done_req();
      end
      sel = 1;
      n_rd = 0;
      access(32'h400, 0, 0, 0, c);
      check("t6 w4 miss cycles", c, 10);
      check("t6 w4 reads", n_rd, 8);
      check("t6 w4 first", first_rd, 32'h400);
      check("t6 w4 last", last_rd, 32'h41C);
      check("t6 w4 data", rdata, pat(32'h400));
      done_req();
      access(32'h41C, 0, 0, 0, c);
      check("t6 w4 hit cycles", c, 0);
      check("t6 w4 hit data", rdata, pat(32'h41C));
      done_req();
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
